obj_line_scan: RTL and testbench

- Per-scanline sprite scanner for the DK Jr video path.
- On each hblank it walks object RAM (96 entries × 4 bytes) and selects sprites whose Y window covers the next line.
- It copies up to 16 hits, 4 bytes each, into the 64×8 single-port sprite line buffer through that RAM's ce/wre/ad/din port.
- It sits directly upstream of the line buffer. The sprite pixel fetcher consumes the buffer together with sprite_count.

---
 rtl/obj_line_scan_if.sv | 19 +
 rtl/obj_line_scan.sv | 135 +++++++++++++
 tb/tb_obj_line_scan.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/obj_line_scan_if.sv
// Memory-side bus of the sprite line scanner: object RAM read port and
// line buffer ce/wre/ad/din port.
interface obj_line_scan_if;
  logic [8:0] obj_addr;
  logic [7:0] obj_data;
  logic       buf_ce;
  logic       buf_wre;
  logic [5:0] buf_ad;
  logic [7:0] buf_din;

  modport master (
    output obj_addr, input obj_data,
    output buf_ce, output buf_wre, output buf_ad, output buf_din
  );
  modport slave (
    input obj_addr, output obj_data,
    input buf_ce, input buf_wre, input buf_ad, input buf_din
  );
endinterface

// File: rtl/obj_line_scan.sv
// Per-scanline sprite scanner: walks object RAM on hblank and copies up to
// MAX_SLOTS hits into the sprite line buffer. OBJ_SCAN_ROWOFS_EN stores row-in-sprite as byte 3.
module obj_line_scan #(
  parameter int NUM_OBJ   = 96,
  parameter int MAX_SLOTS = 16,
  parameter int SPRITE_H  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            vpos,
  obj_line_scan_if.master       bus,
  output logic                  busy,
  output logic                  done,
  output logic [4:0]            sprite_count,
  output logic                  overflow
);
  typedef enum logic [2:0] {IDLE, RD_Y, CHECK, COPY, DRAIN, DONE} state_t;

  localparam logic [7:0] HEIGHT   = 8'(SPRITE_H);
  localparam logic [6:0] LAST_IDX = 7'(NUM_OBJ - 1);
  localparam logic [4:0] FULL     = 5'(MAX_SLOTS);

  state_t     state, state_n;
  logic [7:0] line_r, diff;
  logic [6:0] idx;
  logic [4:0] slot;
  logic [1:0] k;
  logic [8:0] base;
  logic       last, hit, full;
`ifdef OBJ_SCAN_ROWOFS_EN
  logic [3:0] row_r;
`endif

  assign base         = {idx, 2'b00};
  assign diff         = line_r - bus.obj_data;  // mod-256 handles Y wrap
  assign hit          = diff < HEIGHT;
  assign last         = idx == LAST_IDX;
  assign full         = slot == FULL;
  assign sprite_count = slot;
  assign bus.buf_ce   = busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n     = state;
    busy        = 1'b0;
    done        = 1'b0;
    bus.obj_addr = '0;
    bus.buf_wre = 1'b0;
    bus.buf_ad  = '0;
    bus.buf_din = '0;
    case (state)
      IDLE:  if (start) state_n = RD_Y;
      RD_Y: begin
        busy         = 1'b1;
        bus.obj_addr = base | 9'd3;
        state_n      = CHECK;
      end
      CHECK: begin
        busy = 1'b1;
        if (!hit)     state_n = last ? DONE : RD_Y;
        else if (full) state_n = DONE;
        else          state_n = COPY;
      end
      COPY: begin
        busy         = 1'b1;
        bus.obj_addr = base | {7'd0, k};
        // read data lags address by one cycle, so write byte k-1
        if (k != 2'd0) begin
          bus.buf_wre = 1'b1;
          bus.buf_ad  = {slot[3:0], k - 2'd1};
          bus.buf_din = bus.obj_data;
        end
        if (k == 2'd3) state_n = DRAIN;
      end
      DRAIN: begin
        busy        = 1'b1;
        bus.buf_wre = 1'b1;
        bus.buf_ad  = {slot[3:0], 2'd3};
`ifdef OBJ_SCAN_ROWOFS_EN
        bus.buf_din = {4'd0, row_r};
`else
        bus.buf_din = bus.obj_data;
`endif
        state_n = last ? DONE : RD_Y;
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_r   <= '0;
      idx      <= '0;
      slot     <= '0;
      k        <= '0;
      overflow <= 1'b0;
`ifdef OBJ_SCAN_ROWOFS_EN
      row_r    <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          line_r   <= vpos;
          idx      <= '0;
          slot     <= '0;
          k        <= '0;
          overflow <= 1'b0;
        end
        CHECK: begin
          k <= '0;
`ifdef OBJ_SCAN_ROWOFS_EN
          row_r <= diff[3:0];
`endif
          if (!hit && !last) idx <= idx + 7'd1;
          if (hit && full)   overflow <= 1'b1;
        end
        COPY:  k <= k + 2'd1;
        DRAIN: begin
          slot <= slot + 5'd1;
          if (!last) idx <= idx + 7'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_obj_line_scan.sv
// Directed + random bench for obj_line_scan with object RAM / line buffer
// models and a scoreboard of expected line buffer writes.
module tb_obj_line_scan;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] vpos = '0;
  logic       busy, done, overflow;
  logic [4:0] sprite_count;

  obj_line_scan_if bus();

  obj_line_scan dut (
    .clk(clk), .reset(reset), .start(start), .vpos(vpos), .bus(bus),
    .busy(busy), .done(done), .sprite_count(sprite_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  logic [7:0]  mem  [0:383];
  logic [7:0]  lbuf [0:63];
  logic [13:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;

  always @(posedge clk) bus.obj_data <= mem[bus.obj_addr];
  always @(posedge clk) if (bus.buf_ce && bus.buf_wre) lbuf[bus.buf_ad] <= bus.buf_din;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every buffer write must match the next expected write
  always @(negedge clk) begin
    logic [13:0] e;
    if (done) done_cnt++;
    if (bus.buf_wre) begin
      check("wre_while_busy", busy, 1);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $error("FAIL unexpected_write: observed ad=%0h din=%0h expected none",
               bus.buf_ad, bus.buf_din);
      end else begin
        e = exp_q.pop_front();
        check("buf_write", {bus.buf_ad, bus.buf_din}, e);
      end
    end
  end

  task automatic model(input logic [7:0] line, output int cnt, output int ovf, output int cyc);
    logic [7:0] y, d, b3;
    logic [13:0] w;
    cnt = 0; ovf = 0; cyc = 1;
    for (int n = 0; n < 96; n++) begin
      y = mem[4*n+3];
      d = line - y;
      cyc += 2;
      if (d < 8'd16) begin
        if (cnt == 16) begin
          ovf = 1;
          break;
        end
        for (int b = 0; b < 3; b++) begin
          w = {6'(cnt*4 + b), mem[4*n+b]};
          exp_q.push_back(w);
        end
`ifdef OBJ_SCAN_ROWOFS_EN
        b3 = {4'd0, d[3:0]};
`else
        b3 = y;
`endif
        w = {6'(cnt*4 + 3), b3};
        exp_q.push_back(w);
        cnt++;
        cyc += 5;
      end
    end
  endtask

  task automatic fill(input logic [7:0] y);
    for (int i = 0; i < 384; i++) mem[i] = 8'(i) ^ 8'h5A;
    for (int n = 0; n < 96; n++) mem[4*n+3] = y;
  endtask

  task automatic run_scan(input logic [7:0] line, input int restart_at, input logic [7:0] rs_vpos,
                          output int c);
    int cnt, ovf, cyc;
    model(line, cnt, ovf, cyc);
    done_cnt = 0;
    vpos = line; start = 1'b1;
    @(negedge clk);
    start = 1'b0; c = 1;
    while (!done && c < 400) begin
      if (c == restart_at) begin start = 1'b1; vpos = rs_vpos; end
      else start = 1'b0;
      @(negedge clk);
      c++;
    end
    check("done_cycle", c, cyc);
    check("sprite_count", sprite_count, cnt);
    check("overflow", overflow, ovf);
    check("busy_low_in_done", busy, 0);
    start = 1'b1;  // coincident with DONE: must be ignored
    @(negedge clk);
    start = 1'b0;
    check("start_at_done_ignored", busy, 0);
    @(negedge clk);
    check("done_pulses", done_cnt, 1);
    check("queue_drained", exp_q.size(), 0);
    check("count_holds", sprite_count, cnt);
  endtask

  initial begin
    int c;
    logic [7:0] ln;
    fill(8'hF8);
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wre", bus.buf_wre, 0);
    check("rst_ce", bus.buf_ce, 0);
    check("rst_addr", bus.obj_addr, 0);
    check("rst_count", sprite_count, 0);
    check("rst_ovf", overflow, 0);
    reset = 1'b0;
    @(negedge clk);

    // no hits
    run_scan(8'h40, -1, 8'h00, c);
    check("empty_193", c, 193);

    // single hit on entry 5
    mem[20] = 8'h30; mem[21] = 8'h12; mem[22] = 8'h81; mem[23] = 8'h3C;
    run_scan(8'h40, -1, 8'h00, c);
    check("single_198", c, 198);
    check("lbuf0", lbuf[0], 8'h30);
    check("lbuf1", lbuf[1], 8'h12);
    check("lbuf2", lbuf[2], 8'h81);
`ifdef OBJ_SCAN_ROWOFS_EN
    check("lbuf3", lbuf[3], 8'h04);
`else
    check("lbuf3", lbuf[3], 8'h3C);
`endif

    // 17 hits -> overflow, 16 slots
    fill(8'h00);
    for (int n = 0; n < 17; n++) mem[4*n+3] = 8'h80;
    run_scan(8'h80, -1, 8'h00, c);
    check("ovf_flag", overflow, 1);
    check("ovf_count", sprite_count, 16);

    // wrap hit, diff=16 miss, diff=15 hit
    fill(8'h80);
    mem[43] = 8'hFA; mem[83] = 8'h30; mem[123] = 8'h31;
    run_scan(8'h05, -1, 8'h00, c);
    check("wrap_hit", sprite_count, 1);
    run_scan(8'h40, -1, 8'h00, c);
    check("diff16_miss_diff15_hit", sprite_count, 1);

    // restart while busy: line must not change
    run_scan(8'h05, 50, 8'h40, c);

    // reset mid-COPY
    fill(8'h80);
    mem[3] = 8'h40;
    begin
      int cnt, ovf, cyc;
      model(8'h40, cnt, ovf, cyc);
    end
    vpos = 8'h40; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_wre", bus.buf_wre, 0);
    check("midrst_ce", bus.buf_ce, 0);
    check("midrst_addr", bus.obj_addr, 0);
    check("midrst_din", bus.buf_din, 0);
    check("midrst_count", sprite_count, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    run_scan(8'h40, -1, 8'h00, c);
    check("post_rst_count", sprite_count, 1);

    // random Y tables
    for (int it = 0; it < 4; it++) begin
      ln = 8'($urandom);
      for (int n = 0; n < 96; n++)
        mem[4*n+3] = ln - 8'($urandom_range(0, (it < 2) ? 255 : 40));
      run_scan(ln, -1, 8'h00, c);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
